// File: rtl/divider_param_if.sv
// Operand/result bundle and busy/valid handshake for the sequential divider.
// The master side drives the request; the slave side is the divider itself.
interface divider_param_if #(
   parameter int DIVIDEND_W = 8,
   parameter int DIVISOR_W  = 7
);
   logic                  start;
   logic [DIVIDEND_W-1:0] dividendin;
   logic [DIVISOR_W-1:0]  divisorin;
   logic                  busy;
   logic                  valid;
   logic [DIVIDEND_W-1:0] quotient;
   logic [DIVISOR_W-1:0]  remainder;
   logic                  div_by_zero;
   logic                  overflow;

   modport master (
      output start, dividendin, divisorin,
      input  busy, valid, quotient, remainder, div_by_zero, overflow
   );

   modport slave (
      input  start, dividendin, divisorin,
      output busy, valid, quotient, remainder, div_by_zero, overflow
   );
endinterface

// File: rtl/divider_param.sv
// Parametrised restoring divider, one quotient bit per clock, fixed latency of
// DIVIDEND_W+1 edges from the accepting start edge to valid.
module divider_param #(
   parameter int DIVIDEND_W = 8,
   parameter int DIVISOR_W  = 7,
   parameter int SIGNED     = 0
) (
   input logic           clk,
   input logic           reset,
   divider_param_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } stateT;

   localparam int CNT_W = $clog2(DIVIDEND_W + 1);
   localparam logic [CNT_W-1:0]      LAST_ITER = CNT_W'(DIVIDEND_W);
   localparam logic [DIVIDEND_W-1:0] MOST_NEG  = {1'b1, {(DIVIDEND_W-1){1'b0}}};

   stateT                 stateQ, stateD;
   logic [CNT_W-1:0]      cntQ, cntD;
   logic [DIVIDEND_W-1:0] dvdQ, dvdD;
   logic [DIVISOR_W-1:0]  dvsQ, dvsD;
   logic [DIVISOR_W-1:0]  accQ, accD;
   logic                  negQuotQ, negQuotD;
   logic                  negRemQ, negRemD;
   logic                  zeroDivQ, zeroDivD;
   logic                  ovfPendQ, ovfPendD;
   logic [DIVIDEND_W-1:0] quotientQ, quotientD;
   logic [DIVISOR_W-1:0]  remainderQ, remainderD;
   logic                  divByZeroQ, divByZeroD;
   logic                  overflowQ, overflowD;

   logic                  dvdNeg, dvsNeg;
   logic [DIVIDEND_W-1:0] dvdMag;
   logic [DIVISOR_W-1:0]  dvsMag;
   logic [DIVISOR_W:0]    shifted;
   logic                  fits;

   // Magnitudes are unsigned W-bit values, so the most negative operand
   // (2^(W-1)) is still representable without an extra bit.
   always_comb begin
      dvdNeg  = (SIGNED != 0) && bus.dividendin[DIVIDEND_W-1];
      dvsNeg  = (SIGNED != 0) && bus.divisorin[DIVISOR_W-1];
      dvdMag  = dvdNeg ? -bus.dividendin : bus.dividendin;
      dvsMag  = dvsNeg ? -bus.divisorin : bus.divisorin;
      shifted = {accQ, dvdQ[DIVIDEND_W-1]};
      fits    = shifted >= {1'b0, dvsQ};
   end

   always_comb begin
      stateD      = stateQ;
      cntD        = cntQ;
      dvdD        = dvdQ;
      dvsD        = dvsQ;
      accD        = accQ;
      negQuotD    = negQuotQ;
      negRemD     = negRemQ;
      zeroDivD    = zeroDivQ;
      ovfPendD    = ovfPendQ;
      quotientD   = quotientQ;
      remainderD  = remainderQ;
      divByZeroD  = divByZeroQ;
      overflowD   = overflowQ;

      case (stateQ)
         IDLE, DONE: begin
            if (bus.start) begin
               stateD   = RUN;
               cntD     = '0;
               dvdD     = dvdMag;
               dvsD     = dvsMag;
               accD     = '0;
               negQuotD = dvdNeg ^ dvsNeg;
               negRemD  = dvdNeg;
               zeroDivD = (bus.divisorin == '0);
               ovfPendD = (SIGNED != 0) && (bus.dividendin == MOST_NEG) && (&bus.divisorin);
            end
         end
         RUN: begin
            if (cntQ != LAST_ITER) begin
               // Dividend register doubles as the quotient shift register.
               cntD = cntQ + 1'b1;
               accD = fits ? DIVISOR_W'(shifted - {1'b0, dvsQ}) : shifted[DIVISOR_W-1:0];
               dvdD = {dvdQ[DIVIDEND_W-2:0], fits};
            end else begin
               stateD = DONE;
               if (zeroDivQ) begin
                  quotientD  = '1;
                  remainderD = '0;
                  divByZeroD = 1'b1;
                  overflowD  = 1'b0;
               end else begin
                  // Overflow needs no special path: 2^(W-1) wraps to the most negative value.
                  quotientD  = negQuotQ ? -dvdQ : dvdQ;
                  remainderD = negRemQ ? -accQ : accQ;
                  divByZeroD = 1'b0;
                  overflowD  = ovfPendQ;
               end
            end
         end
         default: stateD = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stateQ     <= IDLE;
         cntQ       <= '0;
         dvdQ       <= '0;
         dvsQ       <= '0;
         accQ       <= '0;
         negQuotQ   <= 1'b0;
         negRemQ    <= 1'b0;
         zeroDivQ   <= 1'b0;
         ovfPendQ   <= 1'b0;
         quotientQ  <= '0;
         remainderQ <= '0;
         divByZeroQ <= 1'b0;
         overflowQ  <= 1'b0;
      end else begin
         stateQ     <= stateD;
         cntQ       <= cntD;
         dvdQ       <= dvdD;
         dvsQ       <= dvsD;
         accQ       <= accD;
         negQuotQ   <= negQuotD;
         negRemQ    <= negRemD;
         zeroDivQ   <= zeroDivD;
         ovfPendQ   <= ovfPendD;
         quotientQ  <= quotientD;
         remainderQ <= remainderD;
         divByZeroQ <= divByZeroD;
         overflowQ  <= overflowD;
      end
   end

   assign bus.busy        = (stateQ == RUN);
   assign bus.valid       = (stateQ == DONE);
   assign bus.quotient    = quotientQ;
   assign bus.remainder   = remainderQ;
   assign bus.div_by_zero = divByZeroQ;
   assign bus.overflow    = overflowQ;

endmodule
